// File: rtl/ramen_pkg.sv
// Shared types and constants for the ramen order arbiter: ramen types,
// portion encodings, arbiter FSM states and sold_num field helpers.
package ramen_pkg;

  typedef enum logic [1:0] {
    TONKOTSU     = 2'd0,
    TONKOTSU_SOY = 2'd1,
    MISO         = 2'd2,
    MISO_SOY     = 2'd3
  } ramen_type_e;

  localparam logic PORTION_SMALL = 1'b0;
  localparam logic PORTION_BIG   = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_SEND0 = 3'd2;
  localparam logic [2:0] ST_SEND1 = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;
  localparam logic [2:0] ST_CLOSE = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  // sold_num packs {T, TS, M, MS} at 27:21, 20:14, 13:7 and 6:0.
  localparam int SOLD_FIELD_W = 7;

  function automatic logic [SOLD_FIELD_W-1:0] sold_field(input logic [27:0] sold,
                                                         input ramen_type_e t);
    return sold[27 - SOLD_FIELD_W*int'(t) -: SOLD_FIELD_W];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr,
// wrapping, so the last winner has lowest priority.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!any && req[(int'(ptr) + i) % NUM_REQ]) begin
        any                                = 1'b1;
        grant[(int'(ptr) + i) % NUM_REQ]   = 1'b1;
        idx                                = IDX_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/ramen_order_arb.sv
// Front-end arbiter for the ramen kitchen: round-robin order grant, two-beat
// kitchen handshake, verdict routing and session totals. Optional
// per-station success counters under `define RAMEN_ARB_STATS_EN.
module ramen_order_arb
  import ramen_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sess_start,
  input  logic                   sess_end,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [2*NUM_REQ-1:0]   req_type,
  input  logic [NUM_REQ-1:0]     req_portion,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic                   rsp_success,
  output logic                   k_selling,
  output logic                   k_in_valid,
  output logic [1:0]             k_ramen_type,
  output logic                   k_portion,
  input  logic                   k_out_valid_order,
  input  logic                   k_success,
  input  logic                   k_out_valid_tot,
  input  logic [27:0]            k_sold_num,
  input  logic [14:0]            k_total_gain,
  output logic                   tot_valid,
  output logic [27:0]            tot_sold_num,
  output logic [14:0]            tot_gain,
  output logic                   timeout_err
`ifdef RAMEN_ARB_STATS_EN
 ,output logic [8*NUM_REQ-1:0]   stat_ok
`endif
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [2:0]         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   g_idx;
  logic               portion_q;
  logic               opened;
  logic               close_pend;
  logic [TMR_W-1:0]   timer;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  ramen_type_e        gnt_type;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign gnt_type = ramen_type_e'(req_type[2*gnt_idx +: 2]);

  // Outputs are set on the edge that enters the state they belong to, so the
  // value seen in a state is the one assigned when transitioning into it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= IDX_W'(NUM_REQ - 1);
      g_idx        <= '0;
      portion_q    <= PORTION_SMALL;
      opened       <= 1'b0;
      close_pend   <= 1'b0;
      timer        <= '0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_success  <= 1'b0;
      k_selling    <= 1'b0;
      k_in_valid   <= 1'b0;
      k_ramen_type <= 2'd0;
      k_portion    <= PORTION_SMALL;
      tot_valid    <= 1'b0;
      tot_sold_num <= '0;
      tot_gain     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments; a later assignment in the case below
      // overrides these one-cycle defaults.
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_success  <= 1'b0;
      k_in_valid   <= 1'b0;
      k_ramen_type <= 2'd0;
      k_portion    <= PORTION_SMALL;
      tot_valid    <= 1'b0;

      if (state != ST_IDLE && sess_end) close_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (sess_start) begin
            state       <= ST_ARB;
            opened      <= 1'b0;
            close_pend  <= sess_end;
            timeout_err <= 1'b0;
          end
        end

        ST_ARB: begin
          if (close_pend) begin
            if (opened) begin
              state     <= ST_CLOSE;
              k_selling <= 1'b0;
              timer     <= '0;
            end else begin
              state        <= ST_DONE;
              tot_valid    <= 1'b1;
              tot_sold_num <= '0;
              tot_gain     <= '0;
            end
          end else if (gnt_any) begin
            state        <= ST_SEND0;
            req_ready    <= gnt;
            g_idx        <= gnt_idx;
            ptr          <= gnt_idx;
            portion_q    <= req_portion[gnt_idx];
            k_in_valid   <= 1'b1;
            k_ramen_type <= gnt_type;
            k_selling    <= 1'b1;
          end
        end

        ST_SEND0: begin
          state      <= ST_SEND1;
          opened     <= 1'b1;
          k_in_valid <= 1'b1;
          k_portion  <= portion_q;
        end

        ST_SEND1: begin
          state <= ST_WAIT;
          timer <= '0;
        end

        ST_WAIT: begin
          if (k_out_valid_order) begin
            state       <= ST_RESP;
            rsp_valid   <= NUM_REQ'(1) << g_idx;
            rsp_success <= k_success;
          end else if (timer == TMR_W'(TIMEOUT)) begin
            state       <= ST_RESP;
            rsp_valid   <= NUM_REQ'(1) << g_idx;
            rsp_success <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_RESP: state <= ST_ARB;

        ST_CLOSE: begin
          if (k_out_valid_tot) begin
            state        <= ST_DONE;
            tot_valid    <= 1'b1;
            tot_sold_num <= k_sold_num;
            tot_gain     <= k_total_gain;
          end else if (timer == TMR_W'(TIMEOUT)) begin
            state        <= ST_DONE;
            tot_valid    <= 1'b1;
            tot_sold_num <= '0;
            tot_gain     <= '0;
            timeout_err  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_DONE: begin
          state      <= ST_IDLE;
          close_pend <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RAMEN_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ok <= '0;
    end else if (state == ST_IDLE && sess_start) begin
      stat_ok <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid[i] && rsp_success && stat_ok[8*i +: 8] != 8'hFF)
          stat_ok[8*i +: 8] <= stat_ok[8*i +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ramen_order_arb.sv
// Self-checking bench for ramen_order_arb: directed sequence, scoreboard of
// expected orders, behavioural kitchen and station models.
module tb_ramen_order_arb;
  import ramen_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 15;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sess_start, sess_end;
  logic [NUM_REQ-1:0]   req_valid;
  logic [2*NUM_REQ-1:0] req_type;
  logic [NUM_REQ-1:0]   req_portion;
  logic [NUM_REQ-1:0]   req_ready, rsp_valid;
  logic                 rsp_success;
  logic                 k_selling, k_in_valid, k_portion;
  logic [1:0]           k_ramen_type;
  logic                 k_out_valid_order, k_success, k_out_valid_tot;
  logic [27:0]          k_sold_num;
  logic [14:0]          k_total_gain;
  logic                 tot_valid;
  logic [27:0]          tot_sold_num;
  logic [14:0]          tot_gain;
  logic                 timeout_err;
`ifdef RAMEN_ARB_STATS_EN
  logic [8*NUM_REQ-1:0] stat_ok;
`endif

  ramen_order_arb #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .sess_start        (sess_start),
    .sess_end          (sess_end),
    .req_valid         (req_valid),
    .req_type          (req_type),
    .req_portion       (req_portion),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_success       (rsp_success),
    .k_selling         (k_selling),
    .k_in_valid        (k_in_valid),
    .k_ramen_type      (k_ramen_type),
    .k_portion         (k_portion),
    .k_out_valid_order (k_out_valid_order),
    .k_success         (k_success),
    .k_out_valid_tot   (k_out_valid_tot),
    .k_sold_num        (k_sold_num),
    .k_total_gain      (k_total_gain),
    .tot_valid         (tot_valid),
    .tot_sold_num      (tot_sold_num),
    .tot_gain          (tot_gain),
    .timeout_err       (timeout_err)
`ifdef RAMEN_ARB_STATS_EN
   ,.stat_ok           (stat_ok)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int       station;
    logic [1:0] typ;
    logic     por;
    logic     ok;
    logic     hold;
  } ord_t;

  ord_t sb_q[$];
  ord_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   beat     = 0;
  int   kit_cnt  = 0;
  int   kit_lat  = 1;
  int   wait_entry = 0;
  logic in_flight = 1'b0;
  logic mon_en    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic order(input int s, input logic [1:0] t, input logic p,
                       input logic ok, input logic hold);
    ord_t e;
    e.station = s; e.typ = t; e.por = p; e.ok = ok; e.hold = hold;
    sb_q.push_back(e);
    req_type[2*s +: 2] = t;
    req_portion[s]     = p;
    req_valid[s]       = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb_q.size() != 0 || in_flight) && n < 300) begin
      tick();
      n++;
    end
    check(tag, 32'(sb_q.size() == 0 && !in_flight), 1);
  endtask

  task automatic wait_tot(input string tag, output int t);
    int n = 0;
    while (tot_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(tot_valid), 1);
    t = cyc;
  endtask

  // Station, kitchen and response monitor, all evaluated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        k_out_valid_order = 1'b0;
        if (kit_cnt != 0) begin
          kit_cnt--;
          if (kit_cnt == 0) begin
            k_out_valid_order = 1'b1;
            k_success         = cur.ok;
          end
        end
        if (req_ready != '0) begin
          check("one_in_flight", 32'(in_flight), 0);
          if (sb_q.size() == 0) begin
            check("unexpected_grant", 32'(req_ready), 0);
          end else begin
            cur = sb_q.pop_front();
            check("grant", 32'(req_ready), 32'(1) << cur.station);
          end
          for (int i = 0; i < NUM_REQ; i++)
            if (req_ready[i]) req_valid[i] = 1'b0;
          in_flight = 1'b1;
        end
        if (k_in_valid) begin
          beat++;
          if (beat == 1) begin
            check("type_beat", 32'(k_ramen_type), 32'(cur.typ));
            check("selling_on_type_beat", 32'(k_selling), 1);
          end else if (beat == 2) begin
            check("portion_beat", 32'(k_portion), 32'(cur.por));
            wait_entry = cyc + 1;
            if (!cur.hold) kit_cnt = kit_lat;
          end
        end else if (beat != 0) begin
          check("beat_count", beat, 2);
          beat = 0;
        end
        if (rsp_valid != '0) begin
          check("rsp_expected", 32'(in_flight), 1);
          check("rsp_station", 32'(rsp_valid), 32'(1) << cur.station);
          check("rsp_success", 32'(rsp_success), cur.hold ? 32'd0 : 32'(cur.ok));
          if (cur.hold) check("timeout_latency", cyc - wait_entry, TIMEOUT + 1);
          in_flight = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, n;

    rst = 1'b1; sess_start = 1'b0; sess_end = 1'b0;
    req_valid = '0; req_type = '0; req_portion = '0;
    k_out_valid_order = 1'b0; k_success = 1'b0; k_out_valid_tot = 1'b0;
    k_sold_num = '0; k_total_gain = '0;
    tick(3);

    // Reset state
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_k_selling", 32'(k_selling), 0);
    check("rst_k_in_valid", 32'(k_in_valid), 0);
    check("rst_tot_valid", 32'(tot_valid), 0);
    check("rst_tot_gain", 32'(tot_gain), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    rst = 1'b0; mon_en = 1'b1;
    tick(2);

    // Single order: station 2, TONKOTSU small, kitchen success
    sess_start = 1'b1; tick(); sess_start = 1'b0;
    tick(3);
    check("no_selling_without_order", 32'(k_selling), 0);
    order(2, TONKOTSU, PORTION_SMALL, 1'b1, 1'b0);
    drain("single_drain");
    check("selling_held", 32'(k_selling), 1);

    // Close with an order in flight: sess_end during the portion beat
    kit_lat = 3;
    order(1, MISO, PORTION_BIG, 1'b1, 1'b0);
    n = 0;
    while (k_portion !== 1'b1 && n < 50) begin tick(); n++; end
    check("send1_seen", 32'(k_portion), 1);
    sess_end = 1'b1; tick(); sess_end = 1'b0;
    n = 0;
    while (k_selling !== 1'b0 && n < 50) begin tick(); n++; end
    check("selling_fell", 32'(k_selling), 0);
    check("order_done_before_close", 32'(sb_q.size() == 0 && !in_flight), 1);
    k_out_valid_tot = 1'b1; k_sold_num = 28'h0200000; k_total_gain = 15'd200;
    tick();
    k_out_valid_tot = 1'b0; k_sold_num = '0; k_total_gain = '0;
    wait_tot("close_tot_seen", t1);
    check("close_tot_sold", 32'(tot_sold_num), 32'h0200000);
    check("close_tot_gain", 32'(tot_gain), 200);
    check("close_sold_tonkotsu", 32'(sold_field(tot_sold_num, TONKOTSU)), 1);
    tick();
    check("tot_valid_pulse", 32'(tot_valid), 0);
    kit_lat = 1;

    // sess_end in IDLE is ignored; then a withheld verdict times out
    sess_end = 1'b1; tick(); sess_end = 1'b0; tick(2);
    sess_start = 1'b1; tick(); sess_start = 1'b0;
    order(3, MISO_SOY, PORTION_BIG, 1'b0, 1'b1);
    drain("timeout_drain");
    check("timeout_err_set", 32'(timeout_err), 1);
    order(0, TONKOTSU_SOY, PORTION_SMALL, 1'b1, 1'b0);
    drain("after_timeout_drain");
    sess_start = 1'b1; tick(); sess_start = 1'b0; tick();
    check("sess_start_ignored", 32'(timeout_err), 1);

    // Close whose totals never arrive: zero totals after the timeout
    sess_end = 1'b1; tick(); sess_end = 1'b0;
    wait_tot("close_timeout_tot_seen", t1);
    check("close_timeout_sold", 32'(tot_sold_num), 0);
    check("close_timeout_gain", 32'(tot_gain), 0);
    check("close_timeout_err", 32'(timeout_err), 1);
    tick();

    // Empty session, sess_end one cycle after sess_start
    sess_start = 1'b1; tick(); sess_start = 1'b0;
    check("timeout_err_cleared", 32'(timeout_err), 0);
    sess_end = 1'b1; t0 = cyc; tick(); sess_end = 1'b0;
    wait_tot("empty_tot_seen", t1);
    check("empty_latency", t1 - t0, 2);
    check("empty_selling", 32'(k_selling), 0);
    check("empty_gain", 32'(tot_gain), 0);
    tick();

    // sess_start and sess_end in the same IDLE cycle
    sess_start = 1'b1; sess_end = 1'b1; t0 = cyc; tick();
    sess_start = 1'b0; sess_end = 1'b0;
    wait_tot("same_cycle_tot_seen", t1);
    check("same_cycle_latency", t1 - t0, 2);
    check("same_cycle_selling", 32'(k_selling), 0);
    tick();

    // Reset in the middle of an order drops selling
    sess_start = 1'b1; tick(); sess_start = 1'b0;
    order(2, MISO, PORTION_SMALL, 1'b1, 1'b1);
    n = 0;
    while (!(in_flight && !k_in_valid && beat == 0) && n < 50) begin tick(); n++; end
    tick(3);
    check("mid_order_selling", 32'(k_selling), 1);
    mon_en = 1'b0; rst = 1'b1;
    tick(2);
    check("rst_mid_selling", 32'(k_selling), 0);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 0);
    sb_q.delete(); in_flight = 1'b0; beat = 0; kit_cnt = 0;
    req_valid = '0; k_out_valid_order = 1'b0;
    rst = 1'b0; mon_en = 1'b1;
    tick();

    // Fairness: all stations pending, station 0 re-requests after its grant
    sess_start = 1'b1; tick(); sess_start = 1'b0;
    order(0, TONKOTSU,     PORTION_SMALL, 1'b1, 1'b0);
    order(1, TONKOTSU_SOY, PORTION_BIG,   1'b0, 1'b0);
    order(2, MISO,         PORTION_SMALL, 1'b1, 1'b0);
    order(3, MISO_SOY,     PORTION_BIG,   1'b1, 1'b0);
    n = 0;
    while (req_valid[0] !== 1'b0 && n < 50) begin tick(); n++; end
    check("station0_granted", 32'(req_valid[0]), 0);
    order(0, MISO_SOY, PORTION_BIG, 1'b1, 1'b0);
    drain("fairness_drain");

`ifdef RAMEN_ARB_STATS_EN
    check("stat_after_fairness", 32'(stat_ok), {8'd1, 8'd1, 8'd0, 8'd2});
    sess_end = 1'b1; tick(); sess_end = 1'b0;
    wait_tot("stats_close_seen", t1);
    tick();
    sess_start = 1'b1; tick(); sess_start = 1'b0; tick();
    check("stat_cleared", 32'(stat_ok), 0);
    order(1, MISO, PORTION_SMALL, 1'b1, 1'b0); drain("stat_o1");
    order(1, MISO, PORTION_SMALL, 1'b0, 1'b0); drain("stat_o2");
    order(1, MISO, PORTION_SMALL, 1'b1, 1'b0); drain("stat_o3");
    order(1, MISO, PORTION_SMALL, 1'b1, 1'b0); drain("stat_o4");
    tick();
    check("stat_station1", 32'(stat_ok[15:8]), 3);
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
